// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared definitions for the serial adder.
//   - state_t     : FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   - clog2       : ceiling log2 of a positive integer
//   - count_width : width of the slice counter, clog2(WIDTH/STEP) but never
//                   less than 1 bit so a single-slice build still has a counter
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((32'sd1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int count_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/serial_adder_add1bit.sv
// add1bit: single full-adder cell used in the ripple slice of serial_adder.
// Ports:
//   a, b   in  operand bits
//   c_in   in  carry in
//   sum    out a ^ b ^ c_in
//   c_out  out majority(a, b, c_in)
module add1bit
  import serial_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder that consumes STEP bits of a WIDTH-bit
// operand pair per clock through a STEP-deep ripple of add1bit cells.
// One operation in flight; results held until the consumer accepts them.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the 'sub' port
// (result = a - b - c_in, c_in acting as borrow-in, c_out=1 means no borrow).
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready high only in IDLE)
//   a, b, c_in          operands and carry-in
//   sub                 subtract request (only with SERIAL_ADDER_SUB_EN)
//   out_valid/out_ready result handshake (out_valid high only in DONE)
//   sum, c_out, ovf     registered result, carry-out, signed overflow
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / STEP;
  localparam int CNT_W  = count_width(NSLICE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

  if (WIDTH < 2 || STEP < 1 || STEP > WIDTH || (WIDTH % STEP) != 0) begin : g_bad_param
    $error("serial_adder: need WIDTH>=2, 1<=STEP<=WIDTH, WIDTH%%STEP==0");
  end

  state_t           state_r;
  logic [CNT_W-1:0] count_r;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic             carry_r;
  logic [WIDTH-1:0] sum_r;
  logic             c_out_r;
  logic             ovf_r;
  logic             in_ready_r;
  logic             out_valid_r;

  logic [WIDTH-1:0] b_load_s;
  logic             carry_load_s;
  logic [STEP:0]    chain_s;
  logic [STEP-1:0]  slice_s;
  logic [WIDTH-1:0] sum_next_s;

  // Operand conditioning at accept: subtraction is a + ~b + ~c_in.
  always_comb begin
    b_load_s     = b;
    carry_load_s = c_in;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      b_load_s     = ~b;
      carry_load_s = ~c_in;
    end else begin
      b_load_s     = b;
      carry_load_s = c_in;
    end
`endif
  end

  // Ripple of STEP full-adder cells fed by the low bits of the shift regs.
  assign chain_s[0] = carry_r;
  for (genvar i = 0; i < STEP; i++) begin : g_cell
    add1bit u_cell (
      .a     (a_sr_r[i]),
      .b     (b_sr_r[i]),
      .c_in  (chain_s[i]),
      .sum   (slice_s[i]),
      .c_out (chain_s[i+1])
    );
  end

  // New slice enters sum from the MSB end; after NSLICE slices the first
  // slice has arrived at bit 0.
  if (STEP == WIDTH) begin : g_sum_full
    assign sum_next_s = slice_s;
  end else begin : g_sum_shift
    assign sum_next_s = {slice_s, sum_r[WIDTH-1:STEP]};
  end

  // Control FSM, datapath registers and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      count_r     <= ZERO_CNT;
      a_sr_r      <= ZERO_W;
      b_sr_r      <= ZERO_W;
      carry_r     <= 1'b0;
      sum_r       <= ZERO_W;
      c_out_r     <= 1'b0;
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_sr_r     <= a;
            b_sr_r     <= b_load_s;
            carry_r    <= carry_load_s;
            sum_r      <= ZERO_W;
            count_r    <= ZERO_CNT;
            state_r    <= RUN;
            in_ready_r <= 1'b0;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        RUN: begin
          a_sr_r  <= a_sr_r >> STEP;
          b_sr_r  <= b_sr_r >> STEP;
          sum_r   <= sum_next_s;
          carry_r <= chain_s[STEP];
          count_r <= count_r + ONE_CNT;
          if (count_r == LAST_CNT) begin
            // Final slice holds the MSB: its carry-in vs carry-out gives ovf.
            c_out_r     <= chain_s[STEP];
            ovf_r       <= chain_s[STEP] ^ chain_s[STEP-1];
            state_r     <= DONE;
            out_valid_r <= 1'b1;
          end else begin
            state_r <= RUN;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign c_out     = c_out_r;
  assign ovf       = ovf_r;

endmodule
